// File: rtl/dmem_responder.sv
// Single-cycle CPU data-port responder: word RAM with combinational read plus an
// optional MMIO cycle timer with compare interrupt, enabled by DMEM_MMIO_TIMER_EN.
module dmem_responder #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Irq
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

  logic          w_is_ram;
  logic          w_ram_we;
  logic [AW-1:0] w_ram_idx;
  logic [31:0]   r_mem [DEPTH];

  assign w_is_ram  = (ALUResult < RAM_BYTES);
  assign w_ram_idx = ALUResult[AW+1:2];
  assign w_ram_we  = MemWrite && w_is_ram && reset;

  // NOTE: the RAM array has no reset branch; clearing a memory costs a write
  // port per word, and software never relies on power-up contents.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[w_ram_idx] <= WriteData;
    end
  end

`ifdef DMEM_MMIO_TIMER_EN

  typedef enum logic [1:0] {
    REG_CYCLE   = 2'd0,
    REG_COMPARE = 2'd1,
    REG_STATUS  = 2'd2,
    REG_CTRL    = 2'd3
  } mmio_reg_e;

  logic        w_is_mmio;
  logic        w_mmio_wr;
  logic        w_match_set;
  logic        w_match_clr;
  mmio_reg_e   w_reg;
  logic [31:0] r_cycle;
  logic [31:0] r_compare;
  logic        r_match;
  logic        r_ien;

  // Misaligned offsets inside the timer window behave as unmapped.
  assign w_is_mmio   = (ALUResult[31:4] == 28'hFFFF000) && (ALUResult[1:0] == 2'b00);
  assign w_reg       = mmio_reg_e'(ALUResult[3:2]);
  assign w_mmio_wr   = MemWrite && w_is_mmio;
  assign w_match_set = (r_cycle == r_compare);
  assign w_match_clr = w_mmio_wr && (w_reg == REG_STATUS) && WriteData[0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the match compare relies on the old COMPARE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle   <= 32'h0000_0000;
      r_compare <= 32'hFFFF_FFFF;
      r_match   <= 1'b0;
      r_ien     <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      r_match <= w_match_set || (r_match && !w_match_clr);
      if (w_mmio_wr && (w_reg == REG_COMPARE)) begin
        r_compare <= WriteData;
      end
      if (w_mmio_wr && (w_reg == REG_CTRL)) begin
        r_ien <= WriteData[0];
      end
    end
  end

  assign Irq = r_match && r_ien;

  // NOTE: ReadData gets a default before any branch so no latch is inferred.
  always_comb begin
    ReadData = 32'h0000_0000;
    if (w_is_ram) begin
      ReadData = r_mem[w_ram_idx];
    end else if (w_is_mmio) begin
      case (w_reg)
        REG_CYCLE:   ReadData = r_cycle;
        REG_COMPARE: ReadData = r_compare;
        REG_STATUS:  ReadData = {31'b0, r_match};
        REG_CTRL:    ReadData = {31'b0, r_ien};
        default:     ReadData = 32'h0000_0000;
      endcase
    end
  end

`else

  assign Irq = 1'b0;

  always_comb begin
    ReadData = 32'h0000_0000;
    if (w_is_ram) begin
      ReadData = r_mem[w_ram_idx];
    end
  end

`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM access, address decode, and (when
// DMEM_MMIO_TIMER_EN is defined) the cycle timer, match/W1C and async reset.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Irq;

  int          n_tests;
  int          n_fail;
  logic [31:0] exp_cycle;
  logic [31:0] tgt;

  dmem_responder #(.DEPTH(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Irq       (Irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Counts edges seen while out of reset, i.e. the expected CYCLE value.
  task automatic tick();
    @(posedge clk);
    if (reset) exp_cycle++;
    #1;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    MemWrite  = 1'b0;
    ALUResult = addr;
    #1;
    check(tag, ReadData, exp);
  endtask

  task automatic irq_check(input string tag, input logic exp);
    check(tag, {31'b0, Irq}, {31'b0, exp});
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    ALUResult = addr;
    WriteData = data;
    MemWrite  = 1'b1;
    tick();
    MemWrite  = 1'b0;
  endtask

  task automatic run_to(input logic [31:0] target);
    for (int i = 0; i < 64 && exp_cycle != target; i++) tick();
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    exp_cycle = 32'd0;
    reset     = 1'b0;
    MemWrite  = 1'b0;
    ALUResult = 32'd0;
    WriteData = 32'd0;
    tick();
    tick();

    irq_check("rst_irq", 1'b0);
`ifdef DMEM_MMIO_TIMER_EN
    rd_check("rst_cycle",   32'hFFFF_0000, 32'h0000_0000);
    rd_check("rst_compare", 32'hFFFF_0004, 32'hFFFF_FFFF);
    rd_check("rst_status",  32'hFFFF_0008, 32'h0000_0000);
    rd_check("rst_ctrl",    32'hFFFF_000C, 32'h0000_0000);
`else
    rd_check("rst_mmio0", 32'hFFFF_0000, 32'h0000_0000);
    rd_check("rst_mmio4", 32'hFFFF_0004, 32'h0000_0000);
`endif

    // Release between edges so the next edge is the first increment.
    reset = 1'b1;
    repeat (10) tick();
`ifdef DMEM_MMIO_TIMER_EN
    rd_check("cycle_10", 32'hFFFF_0000, 32'h0000_000A);
    wr(32'hFFFF_0000, 32'h0000_1234);
    rd_check("cycle_ro", 32'hFFFF_0000, 32'h0000_000B);
`endif

    // RAM write, word-aligned reads, and read-during-write returning old data.
    wr(32'h0000_0010, 32'h1111_1111);
    ALUResult = 32'h0000_0010;
    WriteData = 32'hDEAD_BEEF;
    MemWrite  = 1'b1;
    #1;
    check("ram_rdw_old", ReadData, 32'h1111_1111);
    tick();
    MemWrite = 1'b0;
    rd_check("ram_rd_10", 32'h0000_0010, 32'hDEAD_BEEF);
    rd_check("ram_rd_13", 32'h0000_0013, 32'hDEAD_BEEF);
    wr(32'h0000_0000, 32'h0BAD_F00D);
    wr(32'h0000_00FC, 32'hA5A5_A5A5);
    rd_check("ram_last",  32'h0000_00FC, 32'hA5A5_A5A5);
    rd_check("ram_first", 32'h0000_0000, 32'h0BAD_F00D);
    rd_check("ram_keep",  32'h0000_0010, 32'hDEAD_BEEF);

    // Unmapped addresses must not alias onto RAM or timer registers.
    rd_check("unmap_1000_rd", 32'h0000_1000, 32'h0000_0000);
    wr(32'h0000_1000, 32'hFFFF_FFFF);
    rd_check("unmap_1000_wr", 32'h0000_0000, 32'h0BAD_F00D);
    rd_check("misalign_rd",   32'hFFFF_0002, 32'h0000_0000);
    rd_check("outside_rd",    32'hFFFF_0010, 32'h0000_0000);
    wr(32'hFFFF_0010, 32'h0000_0000);
    rd_check("outside_wr",    32'h0000_0010, 32'hDEAD_BEEF);
    wr(32'hFFFF_0006, 32'h0000_0005);
    wr(32'hFFFF_000E, 32'h0000_0001);
    irq_check("misalign_irq", 1'b0);
`ifdef DMEM_MMIO_TIMER_EN
    rd_check("misalign_cmp",  32'hFFFF_0004, 32'hFFFF_FFFF);
    rd_check("misalign_ctrl", 32'hFFFF_000C, 32'h0000_0000);

    // Compare match, Irq, W1C behaviour.
    tgt = exp_cycle + 32'd6;
    wr(32'hFFFF_0004, tgt);
    wr(32'hFFFF_000C, 32'h0000_0001);
    rd_check("cmp_wr",  32'hFFFF_0004, tgt);
    rd_check("ctrl_wr", 32'hFFFF_000C, 32'h0000_0001);
    run_to(tgt);
    irq_check("pre_match_irq", 1'b0);
    rd_check("pre_match_status", 32'hFFFF_0008, 32'h0000_0000);
    tick();
    irq_check("match_irq", 1'b1);
    rd_check("match_status", 32'hFFFF_0008, 32'h0000_0001);
    rd_check("match_cycle",  32'hFFFF_0000, tgt + 32'd1);
    wr(32'hFFFF_0008, 32'h0000_0000);
    rd_check("w0_status", 32'hFFFF_0008, 32'h0000_0001);
    wr(32'hFFFF_0008, 32'h0000_0001);
    irq_check("w1c_irq", 1'b0);
    rd_check("w1c_status", 32'hFFFF_0008, 32'h0000_0000);

    // Set and W1C clear in the same cycle: set wins.
    tgt = exp_cycle + 32'd3;
    wr(32'hFFFF_0004, tgt);
    run_to(tgt);
    wr(32'hFFFF_0008, 32'h0000_0001);
    rd_check("set_wins_status", 32'hFFFF_0008, 32'h0000_0001);
    irq_check("set_wins_irq", 1'b1);
    wr(32'hFFFF_0008, 32'h0000_0001);
    rd_check("clear_again", 32'hFFFF_0008, 32'h0000_0000);

    // COMPARE rewritten in the matching cycle: old value still matches.
    tgt = exp_cycle + 32'd3;
    wr(32'hFFFF_0004, tgt);
    run_to(tgt);
    wr(32'hFFFF_0004, 32'h0000_0007);
    rd_check("old_cmp_match", 32'hFFFF_0008, 32'h0000_0001);
    rd_check("new_cmp_value", 32'hFFFF_0004, 32'h0000_0007);
    irq_check("old_cmp_irq", 1'b1);

    // Asynchronous reset with Irq high: clears before the next edge.
    reset     = 1'b0;
    exp_cycle = 32'd0;
    #1;
    irq_check("async_irq", 1'b0);
    rd_check("async_cycle",   32'hFFFF_0000, 32'h0000_0000);
    rd_check("async_compare", 32'hFFFF_0004, 32'hFFFF_FFFF);
    rd_check("async_status",  32'hFFFF_0008, 32'h0000_0000);
    rd_check("async_ctrl",    32'hFFFF_000C, 32'h0000_0000);
`else
    wr(32'hFFFF_0000, 32'h1234_5678);
    rd_check("mmio_off_alias", 32'h0000_0000, 32'h0BAD_F00D);
    rd_check("mmio_off_rd",    32'hFFFF_0000, 32'h0000_0000);
    wr(32'hFFFF_000C, 32'h0000_0001);
    wr(32'hFFFF_0004, 32'h0000_0000);
    repeat (4) tick();
    irq_check("mmio_off_irq", 1'b0);
    rd_check("mmio_off_status", 32'hFFFF_0008, 32'h0000_0000);
    reset     = 1'b0;
    exp_cycle = 32'd0;
    #1;
    irq_check("async_irq", 1'b0);
    rd_check("async_mmio", 32'hFFFF_0000, 32'h0000_0000);
`endif
    rd_check("rst_ram_kept", 32'h0000_0010, 32'hDEAD_BEEF);

    // Writes are blocked while reset is held.
    ALUResult = 32'h0000_0010;
    WriteData = 32'h0000_0000;
    MemWrite  = 1'b1;
    tick();
    MemWrite = 1'b0;
    rd_check("rst_wr_blocked", 32'h0000_0010, 32'hDEAD_BEEF);
`ifdef DMEM_MMIO_TIMER_EN
    rd_check("rst_cycle_held", 32'hFFFF_0000, 32'h0000_0000);
`endif

    reset = 1'b1;
    repeat (3) tick();
    irq_check("post_rst_irq", 1'b0);
`ifdef DMEM_MMIO_TIMER_EN
    rd_check("post_rst_cycle", 32'hFFFF_0000, exp_cycle);
    rd_check("post_rst_cyc3",  32'hFFFF_0000, 32'h0000_0003);
`else
    rd_check("post_rst_mmio", 32'hFFFF_0000, 32'h0000_0000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 64, the number of 32-bit RAM words (power of two, 4..4096).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset; clears all registers while low.
REQ-004 MemWrite  input  1  CPU data-port write strobe; sampled on the rising clk edge.
REQ-005 ALUResult  input  32  CPU byte address for the data access.
REQ-006 WriteData  input  32  CPU store data.
REQ-007 ReadData  output  32  load data returned to the CPU in the same cycle.
REQ-008 Irq  output  1  timer interrupt request, level.

Function
REQ-009 Decode: RAM when ALUResult < DEPTH*4; MMIO when ALUResult[31:4] == 0xFFFF000; otherwise unmapped.
REQ-010 RAM index SHALL be ALUResult[log2(DEPTH)+1:2]; ALUResult[1:0] ignored (word access only).
REQ-011 ReadData SHALL be combinational from ALUResult and current state, zero clock latency, to match the single-cycle CPU.
REQ-012 RAM write on rising clk when MemWrite=1 and address decodes to RAM; a read of the same word in that cycle returns the old value.
REQ-013 MMIO map (offset = ALUResult[3:0]): 0x0 CYCLE (RO), 0x4 COMPARE (RW), 0x8 STATUS (bit0 MATCH, W1C), 0xC CTRL (bit0 IEN, RW); unused bits read 0.
REQ-014 CYCLE SHALL increment by 1 every clk edge out of reset and wrap 0xFFFF_FFFF -> 0x0000_0000; writes to CYCLE are ignored.
REQ-015 MATCH SHALL set on the edge where the pre-edge CYCLE equals the pre-edge COMPARE.
REQ-016 A write of 1 to STATUS bit0 SHALL clear MATCH; writing 0 has no effect.
REQ-017 Simultaneous set condition and W1C clear in one cycle: set wins, MATCH stays 1.
REQ-018 A COMPARE write in a cycle where CYCLE equals the old COMPARE: match uses the old COMPARE; new value takes effect next cycle.
REQ-019 Irq SHALL equal MATCH AND IEN, driven from registers only (no combinational path from inputs).
REQ-020 Unmapped or misaligned (ALUResult[1:0]!=0) MMIO accesses: reads return 0x0000_0000, writes ignored, no state change.

Reset
REQ-021 While reset=0: CYCLE=0, COMPARE=0xFFFF_FFFF, MATCH=0, IEN=0, Irq=0.
REQ-022 RAM contents SHALL NOT be reset; writes SHALL be blocked while reset=0.
REQ-023 Reset asserted mid-operation SHALL clear state immediately without waiting for clk; first CYCLE increment is on the first edge after reset deasserts.

Configuration
REQ-024 Macro DMEM_MMIO_TIMER_EN SHALL gate the timer: defined -> REQ-013..REQ-019 implemented; undefined -> no timer registers, MMIO region decodes as unmapped (reads 0, writes ignored), Irq tied to 0.

Verification
REQ-025 Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 and 0x0000_0013 -> both return 0xDEADBEEF; same-cycle read during write returns prior value.
REQ-026 Release reset, read 0xFFFF_0000 after 10 edges -> 0x0000_000A; write 0x1234 to it -> next read still counts normally.
REQ-027 Write COMPARE=20, CTRL=1 -> MATCH and Irq go 1 on edge after CYCLE==20; write 0x1 to 0xFFFF_0008 -> Irq 0 next edge.
REQ-028 Force CYCLE==COMPARE in the same cycle as a W1C to STATUS -> MATCH remains 1.
REQ-029 Read 0x0000_1000 (DEPTH=64) and 0xFFFF_0002 -> 0x0000_0000; writes there leave all RAM and registers unchanged.
REQ-030 Assert reset asynchronously mid-count with Irq=1 -> Irq, CYCLE, MATCH, IEN clear before next clk; COMPARE reads 0xFFFF_FFFF; with DMEM_MMIO_TIMER_EN undefined, 0xFFFF_0000 reads 0 and Irq stays 0.
